// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings, bit indices and FSM states
// for the SPI slave datapath.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: peripheral-side TX/RX word streams
// of the SPI slave (valid/ready).
interface spi_slave_sync_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for an async pad input
// with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: PCLK-oversampled SPI slave, all CPOL/CPHA modes.
// Optional LSB-first via `define SPI_SLAVE_LSB_FIRST_EN.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       SCK,
  input  logic       SS,
  input  logic       MOSI,
  output wire        MISO,
  input  logic [1:0] MODE,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic       lsb_first,
`endif
  spi_slave_sync_if.slave strm,
  output logic       busy,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       err_clr
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
  logic sck_unused_q, ss_unused_q;
  logic mosi_unused_rise, mosi_unused_fall;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              ovr_q, ovr_d;
  logic              und_q, und_d;
  logic              lead, trail, accept, lsb;
  logic              do_load, do_shift, do_sample;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(PCLK), .rst_n(PRESETn), .d(SCK),
    .q(sck_unused_q), .rise(sck_rise), .fall(sck_fall)
  );

  // Reset to "selected" so a reset with SS held low cannot
  // fake an SS fall; a frame needs a genuine new SS fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss (
    .clk(PCLK), .rst_n(PRESETn), .d(SS),
    .q(ss_unused_q), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(PCLK), .rst_n(PRESETn), .d(MOSI),
    .q(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
  );

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_q, lsb_d;

  always_comb begin
    lsb_d = lsb_q;
    if (state_q == IDLE && ss_fall) lsb_d = lsb_first;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) lsb_q <= 1'b0;
    else          lsb_q <= lsb_d;
  end

  assign lsb = lsb_q;
`else
  assign lsb = 1'b0;
`endif

  assign lead   = mode_q[CPOL_BIT] ? sck_fall : sck_rise;
  assign trail  = mode_q[CPOL_BIT] ? sck_rise : sck_fall;
  assign accept = rx_valid_q & strm.rx_ready;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~accept;
    tx_ready_d = 1'b0;
    ovr_d      = ovr_q;
    und_d      = und_q;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;
    unique case (state_q)
      IDLE: if (ss_fall) begin
        state_d = ACTIVE;
        mode_d  = MODE;
        cnt_d   = '0;
        do_load = ~MODE[CPHA_BIT];
      end
      ACTIVE: if (ss_rise) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (mode_q[CPHA_BIT]) begin
        do_sample = trail;
        do_load   = lead & (cnt_q == '0);
        do_shift  = lead & (cnt_q != '0);
      end else begin
        do_sample = lead;
        do_load   = trail & (cnt_q == '0);
        do_shift  = trail & (cnt_q != '0);
      end
      default: state_d = IDLE;
    endcase
    if (do_load) begin
      if (strm.tx_valid) begin
        tx_sr_d    = strm.tx_data;
        tx_ready_d = 1'b1;
      end else begin
        tx_sr_d = '0;
        und_d   = 1'b1;
      end
    end
    if (do_shift)
      tx_sr_d = lsb ? {1'b0, tx_sr_q[DATA_W-1:1]}
                    : {tx_sr_q[DATA_W-2:0], 1'b0};
    if (do_sample) begin
      rx_sr_d = lsb ? {mosi_s, rx_sr_q[DATA_W-1:1]}
                    : {rx_sr_q[DATA_W-2:0], mosi_s};
      if (cnt_q == LAST) begin
        cnt_d = '0;
        if (!rx_valid_q || accept) begin
          rx_data_d  = rx_sr_d;
          rx_valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (err_clr) begin
      ovr_d = 1'b0;
      und_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
    end
  end

  assign MISO = SS ? 1'bz
              : (lsb ? tx_sr_q[0] : tx_sr_q[DATA_W-1]);

  assign strm.tx_ready = tx_ready_q;
  assign strm.rx_data  = rx_data_q;
  assign strm.rx_valid = rx_valid_q;
  assign busy          = (state_q == ACTIVE);
  assign rx_overrun    = ovr_q;
  assign tx_underrun   = und_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: table + random frames for spi_slave_sync
// against a word-level model of the SPI slave.
module tb_spi_slave_sync;
  import spi_pkg::*;

  localparam int DW = 8;
  localparam int HP = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       SCK = 1'b0;
  logic       SS = 1'b1;
  logic       MOSI = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] MODE = 2'd0;
  wire        MISO;
  logic       busy, rx_overrun, tx_underrun;

  spi_slave_sync_if #(.DATA_W(DW)) intf();

  spi_slave_sync #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .SCK(SCK),
    .SS(SS),
    .MOSI(MOSI),
    .MISO(MISO),
    .MODE(MODE),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .strm(intf),
    .busy(busy),
    .rx_overrun(rx_overrun),
    .tx_underrun(tx_underrun),
    .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  mode;
    int          nw;
    logic [7:0]  mo [3];
    int          ntx;
    logic [7:0]  tx [3];
    logic        rdy;
    logic [23:0] e_miso;
    logic [7:0]  e_rx0;
    logic        e_ovr;
    logic        e_und;
    int          e_txr;
  } vec_t;

  int         n_tests = 0;
  int         n_fail = 0;
  int         txr_cnt = 0;
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  logic       sb;
  vec_t       vt [8];
  vec_t       vr;

  // Peripheral-side source and sink, driven away from posedge.
  always @(negedge PCLK) begin
    if (intf.tx_ready) begin
      if (txq.size() > 0) void'(txq.pop_front());
      txr_cnt++;
    end
    if (intf.rx_valid && intf.rx_ready) rxq.push_back(intf.rx_data);
    intf.tx_valid = (txq.size() > 0);
    intf.tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic ss_start(input logic [1:0] m);
    MODE = m;
    SCK  = m[1];
    clks(HP);
    SS = 1'b0;
    clks(HP);
    MODE = ~m;
  endtask

  task automatic ss_stop();
    clks(HP);
    SS = 1'b1;
    clks(2 * HP);
  endtask

  task automatic xfer_bit(input logic [1:0] m, input logic b,
                          output logic s);
    if (!m[0]) begin
      MOSI = b;
      clks(HP);
      s   = MISO;
      SCK = ~m[1];
      clks(HP);
      SCK = m[1];
    end else begin
      SCK  = ~m[1];
      MOSI = b;
      clks(HP);
      s   = MISO;
      SCK = m[1];
      clks(HP);
    end
  endtask

  task automatic do_frame(input logic [1:0] m, input int nw,
                          input logic [23:0] mw,
                          output logic [23:0] mi);
    logic s;
    mi = '0;
    ss_start(m);
    for (int i = 0; i < nw * 8; i++) begin
      xfer_bit(m, mw[nw*8-1-i], s);
      mi = {mi[22:0], s};
    end
    ss_stop();
  endtask

  task automatic cleanup();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    chk("err_clr", 32'({rx_overrun, tx_underrun}), 32'd0);
    intf.rx_ready = 1'b1;
    clks(4);
    rxq.delete();
    txq.delete();
    txr_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [23:0] mw, mi, rw;
    mw = '0;
    for (int k = 0; k < v.nw; k++) mw = {mw[15:0], v.mo[k]};
    intf.rx_ready = v.rdy;
    for (int k = 0; k < v.ntx; k++) txq.push_back(v.tx[k]);
    clks(2);
    txr_cnt = 0;
    do_frame(v.mode, v.nw, mw, mi);
    chk({tag, "_miso"}, 32'(mi), 32'(v.e_miso));
    if (v.rdy) begin
      rw = '0;
      for (int k = 0; k < rxq.size(); k++) rw = {rw[15:0], rxq[k]};
      chk({tag, "_rxcnt"}, 32'(rxq.size()), 32'(v.nw));
      chk({tag, "_rxwords"}, 32'(rw), 32'(mw));
    end else begin
      chk({tag, "_rxhold"}, 32'({intf.rx_valid, intf.rx_data}),
          32'({1'b1, v.e_rx0}));
    end
    chk({tag, "_ovr"}, 32'(rx_overrun), 32'(v.e_ovr));
    chk({tag, "_und"}, 32'(tx_underrun), 32'(v.e_und));
    chk({tag, "_txready"}, 32'(txr_cnt), 32'(v.e_txr));
    cleanup();
  endtask

  // Word-level model: one load per word (plus one after the last
  // word for CPHA=0); each load takes the next queued word or 0.
  task automatic rand_vec(output vec_t v);
    int loads;
    v.mode = 2'($urandom_range(0, 3));
    v.nw   = $urandom_range(1, 3);
    v.ntx  = $urandom_range(0, 3);
    v.rdy  = 1'($urandom_range(0, 1));
    for (int k = 0; k < 3; k++) begin
      v.mo[k] = 8'($urandom);
      v.tx[k] = 8'($urandom);
    end
    loads    = v.nw + (v.mode[0] ? 0 : 1);
    v.e_miso = '0;
    for (int k = 0; k < v.nw; k++)
      v.e_miso = {v.e_miso[15:0], (k < v.ntx) ? v.tx[k] : 8'h00};
    v.e_rx0 = v.mo[0];
    v.e_ovr = !v.rdy && (v.nw > 1);
    v.e_und = (loads > v.ntx);
    v.e_txr = (loads < v.ntx) ? loads : v.ntx;
  endtask

  initial begin
    intf.rx_ready = 1'b0;
    vt[0] = '{MODE0, 1, '{8'h3C, 8'h00, 8'h00}, 1, '{8'hA5, 8'h00, 8'h00},
              1'b1, 24'h0000A5, 8'h3C, 1'b0, 1'b1, 1};
    vt[1] = '{MODE1, 1, '{8'hC3, 8'h00, 8'h00}, 1, '{8'hC3, 8'h00, 8'h00},
              1'b1, 24'h0000C3, 8'hC3, 1'b0, 1'b0, 1};
    vt[2] = '{MODE2, 1, '{8'hC3, 8'h00, 8'h00}, 1, '{8'hC3, 8'h00, 8'h00},
              1'b1, 24'h0000C3, 8'hC3, 1'b0, 1'b1, 1};
    vt[3] = '{MODE3, 1, '{8'hC3, 8'h00, 8'h00}, 1, '{8'hC3, 8'h00, 8'h00},
              1'b1, 24'h0000C3, 8'hC3, 1'b0, 1'b0, 1};
    vt[4] = '{MODE0, 3, '{8'h11, 8'h22, 8'h33}, 3, '{8'hAA, 8'hBB, 8'hCC},
              1'b0, 24'hAABBCC, 8'h11, 1'b1, 1'b1, 3};
    vt[5] = '{MODE0, 1, '{8'h96, 8'h00, 8'h00}, 0, '{8'h00, 8'h00, 8'h00},
              1'b1, 24'h000000, 8'h96, 1'b0, 1'b1, 0};
    vt[6] = '{MODE3, 2, '{8'hF0, 8'h0F, 8'h00}, 2, '{8'h12, 8'h34, 8'h00},
              1'b1, 24'h001234, 8'hF0, 1'b0, 1'b0, 2};
    vt[7] = '{MODE2, 3, '{8'h81, 8'h7E, 8'hC3}, 3, '{8'h01, 8'h02, 8'h03},
              1'b1, 24'h010203, 8'h81, 1'b0, 1'b1, 3};

    clks(3);
    chk("reset_state", 32'({busy, rx_overrun, tx_underrun, intf.tx_ready,
        intf.rx_valid, intf.rx_data}), 32'd0);
    PRESETn = 1'b1;
    clks(6);
    chk("reset_idle", 32'({busy, rx_overrun, tx_underrun, intf.tx_ready,
        intf.rx_valid, intf.rx_data}), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Partial frame: SS rises after 5 bits, word is discarded.
    intf.rx_ready = 1'b1;
    txq.push_back(8'h99);
    clks(2);
    ss_start(MODE0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) xfer_bit(MODE0, 1'b1, sb);
    ss_stop();
    chk("partial_no_rx", 32'({intf.rx_valid, 8'(rxq.size())}), 32'd0);
    cleanup();
    vr = '{MODE0, 1, '{8'h81, 8'h00, 8'h00}, 0, '{8'h00, 8'h00, 8'h00},
           1'b1, 24'h000000, 8'h81, 1'b0, 1'b1, 0};
    run_vec(vr, "after_partial");

    // Reset mid-word; no frame until a fresh SS fall.
    ss_start(MODE0);
    chk("und_before_rst", 32'(tx_underrun), 32'd1);
    for (int i = 0; i < 3; i++) xfer_bit(MODE0, 1'b1, sb);
    PRESETn = 1'b0;
    clks(2);
    chk("reset_mid", 32'({busy, rx_overrun, tx_underrun, intf.tx_ready,
        intf.rx_valid, intf.rx_data}), 32'd0);
    PRESETn = 1'b1;
    for (int i = 0; i < 5; i++) xfer_bit(MODE0, 1'b0, sb);
    chk("rst_no_busy", 32'(busy), 32'd0);
    ss_stop();
    chk("rst_no_rx", 32'({intf.rx_valid, 8'(rxq.size())}), 32'd0);
    cleanup();
    vr = '{MODE0, 1, '{8'h5A, 8'h00, 8'h00}, 1, '{8'hA5, 8'h00, 8'h00},
           1'b1, 24'h0000A5, 8'h5A, 1'b0, 1'b1, 1};
    run_vec(vr, "after_reset");

    for (int i = 0; i < 12; i++) begin
      rand_vec(vr);
      run_vec(vr, $sformatf("rnd%0d_m%0d", i, vr.mode));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
